// File: rtl/crc_pkg.sv
// Shared definitions for the CRC frame receiver: default polynomial, FSM state
// encoding and a byte bit-reversal helper.
package crc_pkg;

   // CRC-16/CCITT generator polynomial, implicit x^16 term omitted
   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

   // Receiver FSM states
   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StHold
   } rx_state_e;

   // Reverse the bit order of a byte (LSB-first wire order to MSB-first)
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational CRC update for one byte, MSB first, non-reflected.
module crc_byte_step
   import crc_pkg::*;
#(
   parameter int unsigned        CRC_W = 16,
   parameter logic [CRC_W-1:0]   POLY  = CRC_W'(CRC16_CCITT_POLY)
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic [7:0]       data_i,
   output logic [CRC_W-1:0] crc_o
);

   // Shift the eight data bits through the LFSR, data MSB first
   always_comb begin
      logic [CRC_W-1:0] c;
      c = crc_i;
      for (int i = 7; i >= 0; i--) begin
         if (c[CRC_W-1] ^ data_i[i]) begin
            c = {c[CRC_W-2:0], 1'b0} ^ POLY;
         end else begin
            c = {c[CRC_W-2:0], 1'b0};
         end
      end
      crc_o = c;
   end

endmodule

// File: rtl/crc_frame_rx.sv
// Byte-stream frame receiver: collects PAYLOAD_BYTES payload bytes plus a
// CRC_W/8-byte CRC (MSB byte first), checks the CRC and presents the payload
// with a valid/ready handshake.
// Optional build macro CRC_FRAME_RX_TIMEOUT_EN adds an idle-gap timeout that
// discards a partial frame after TIMEOUT_CYC cycles without a byte.
module crc_frame_rx
   import crc_pkg::*;
#(
   parameter int unsigned      PAYLOAD_BYTES = 3,
   parameter int unsigned      CRC_W         = 16,
   parameter logic [CRC_W-1:0] POLY          = CRC_W'(CRC16_CCITT_POLY),
   parameter logic [CRC_W-1:0] CRC_INIT      = '0,
   parameter bit               REFLECT_IN    = 1'b1,
   parameter int unsigned      TIMEOUT_CYC   = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic [7:0]                 byte_i,
   input  logic                       byte_valid_i,
   input  logic                       frame_ready_i,
   output logic [8*PAYLOAD_BYTES-1:0] frame_o,
   output logic                       frame_valid_o,
   output logic                       crc_err_o,
   output logic                       overrun_o,
   output logic                       timeout_o,
   output logic                       busy_o
);

   localparam int unsigned     Total   = PAYLOAD_BYTES + CRC_W / 8;
   localparam int unsigned     CntW    = $clog2(Total);
   localparam logic [CntW-1:0] LastIdx = CntW'(Total - 1);

   rx_state_e                  state_q, state_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [CRC_W-1:0]           crc_q, crc_d;
   logic [8*PAYLOAD_BYTES-1:0] frame_q, frame_d;
   logic                       valid_q, valid_d;
   logic                       err_q, err_d;
   logic                       ovr_q, ovr_d;

   logic [7:0]       byte_in;
   logic             hs;
   logic             accept;
   logic [CRC_W-1:0] crc_seed;
   logic [CRC_W-1:0] crc_step;

   assign byte_in = REFLECT_IN ? bit_rev8(byte_i) : byte_i;
   assign hs      = (state_q == StHold) & frame_ready_i;
   // A handshake in HOLD frees the slot, so a byte in that cycle starts the next frame
   assign accept  = byte_valid_i & en_i &
                    ((state_q == StIdle) | (state_q == StCollect) | hs);
   // Counter is zero outside COLLECT, so byte 0 always seeds from CRC_INIT
   assign crc_seed = (cnt_q == '0) ? CRC_INIT : crc_q;

   crc_byte_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_crc_step (
      .crc_i  (crc_seed),
      .data_i (byte_in),
      .crc_o  (crc_step)
   );

`ifdef CRC_FRAME_RX_TIMEOUT_EN
   localparam int unsigned     TmrW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

   logic [TmrW-1:0] tmr_q, tmr_d;
   logic            to_q, to_d;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

   // Next-state, byte capture, CRC update and status pulses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      frame_d = frame_q;
      valid_d = valid_q;
      err_d   = err_q;
      ovr_d   = 1'b0;
`ifdef CRC_FRAME_RX_TIMEOUT_EN
      tmr_d   = '0;
      to_d    = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
         end
         StCollect: begin
`ifdef CRC_FRAME_RX_TIMEOUT_EN
            if (!accept) begin
               if (tmr_q == TmrLast) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  to_d    = 1'b1;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
`endif
         end
         StHold: begin
            if (hs) begin
               state_d = StIdle;
               cnt_d   = '0;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end else if (byte_valid_i && en_i) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      if (accept) begin
         crc_d = crc_step;
         for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (cnt_q == CntW'(i)) begin
               frame_d[8*(PAYLOAD_BYTES-1-i) +: 8] = byte_in;
            end
         end
         if (cnt_q == LastIdx) begin
            // Remainder over payload plus transmitted CRC is zero for a good frame
            cnt_d   = '0;
            state_d = StHold;
            valid_d = 1'b1;
            err_d   = (crc_step != '0);
         end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StCollect;
         end
      end
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         crc_q   <= CRC_INIT;
         frame_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef CRC_FRAME_RX_TIMEOUT_EN
   // Idle-gap timer and its discard pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmr_q <= '0;
         to_q  <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         to_q  <= to_d;
      end
   end

   assign timeout_o = to_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign frame_o       = frame_q;
   assign frame_valid_o = valid_q;
   assign crc_err_o     = err_q;
   assign overrun_o     = ovr_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_crc_frame_rx.sv
// Self-checking bench for crc_frame_rx: 9-byte payload, CRC-16/XMODEM, no
// input reflection, 16-cycle timeout when CRC_FRAME_RX_TIMEOUT_EN is defined.
module tb_crc_frame_rx;

   localparam int unsigned PB = 9;
   localparam int unsigned FW = 8 * PB;
   localparam int unsigned NB = PB + 2;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          en_i;
   logic [7:0]    byte_i;
   logic          byte_valid_i;
   logic          frame_ready_i;
   logic [FW-1:0] frame_o;
   logic          frame_valid_o;
   logic          crc_err_o;
   logic          overrun_o;
   logic          timeout_o;
   logic          busy_o;

   always #5 clk = ~clk;

   crc_frame_rx #(
      .PAYLOAD_BYTES (PB),
      .CRC_W         (16),
      .POLY          (16'h1021),
      .CRC_INIT      (16'h0000),
      .REFLECT_IN    (1'b0),
      .TIMEOUT_CYC   (16)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .en_i          (en_i),
      .byte_i        (byte_i),
      .byte_valid_i  (byte_valid_i),
      .frame_ready_i (frame_ready_i),
      .frame_o       (frame_o),
      .frame_valid_o (frame_valid_o),
      .crc_err_o     (crc_err_o),
      .overrun_o     (overrun_o),
      .timeout_o     (timeout_o),
      .busy_o        (busy_o)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [FW-1:0] p;
      logic          e;
   } exp_t;

   typedef struct {
      logic [FW-1:0] payload;
      logic [15:0]   crc_tx;
      logic          exp_err;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[5];

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [FW-1:0] act,
                            input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference CRC-16, poly 0x1021, init 0, MSB first, no final XOR
   function automatic logic [15:0] crc16(input logic [FW-1:0] p);
      logic [15:0] c;
      logic [7:0]  b;
      c = 16'h0000;
      for (int i = 0; i < PB; i++) begin
         b = p[FW-1-8*i -: 8];
         for (int j = 7; j >= 0; j--) begin
            if (c[15] ^ b[j]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   // Present one byte for one cycle; called and returns at a falling edge
   task automatic put(input logic [7:0] b);
      byte_i       = b;
      byte_valid_i = 1'b1;
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   // Send a whole frame; optionally strobe a byte with en_i low before byte dis_at
   task automatic send_frame(input logic [FW-1:0] p, input logic [15:0] c,
                             input logic e, input int dis_at);
      exp_t       x;
      logic [7:0] b;
      x.p = p;
      x.e = e;
      sb_q.push_back(x);
      for (int i = 0; i < NB; i++) begin
         if (i == dis_at) begin
            en_i = 1'b0;
            put(8'h55);
            check_bit("no overrun while disabled", overrun_o, 1'b0);
            check_bit("collect kept while disabled", busy_o, 1'b1);
            en_i = 1'b1;
         end
         if (i < PB)       b = p[FW-1-8*i -: 8];
         else if (i == PB) b = c[15:8];
         else              b = c[7:0];
         put(b);
      end
      check_bit("valid one cycle after last byte", frame_valid_o, 1'b1);
   endtask

   // Scoreboard monitor: each newly presented frame pops one expectation
   logic prev_v  = 1'b0;
   logic hs_seen = 1'b0;

   always @(posedge clk) begin
      prev_v  <= frame_valid_o;
      hs_seen <= frame_valid_o & frame_ready_i;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_ni && frame_valid_o && (!prev_v || hs_seen)) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected frame: got %0h expected none", frame_o);
         end else begin
            e = sb_q.pop_front();
            check_vec("frame payload", frame_o, e.p);
            check_bit("frame crc_err", crc_err_o, e.e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected end before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [95:0] r;
      rst_ni        = 1'b0;
      en_i          = 1'b1;
      byte_i        = 8'h00;
      byte_valid_i  = 1'b0;
      frame_ready_i = 1'b1;

      r = {$urandom(), $urandom(), $urandom()};
      vecs[0] = '{72'h313233343536373839, 16'h31C3, 1'b0};
      vecs[1] = '{72'h313233343536373839, 16'h31C2, 1'b1};
      vecs[2] = '{72'h0, crc16(72'h0), 1'b0};
      vecs[3] = '{{9{8'hFF}}, crc16({9{8'hFF}}) ^ 16'h0100, 1'b1};
      vecs[4] = '{r[FW-1:0], crc16(r[FW-1:0]), 1'b0};

      #1;
      check_bit("reset frame_valid_o", frame_valid_o, 1'b0);
      check_bit("reset busy_o", busy_o, 1'b0);
      check_vec("reset frame_o", frame_o, '0);
      check_bit("reset crc_err_o", crc_err_o, 1'b0);
      check_bit("reset overrun_o", overrun_o, 1'b0);
      check_bit("reset timeout_o", timeout_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;

      // Table of frames, consumer always ready
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].payload, vecs[i].crc_tx, vecs[i].exp_err, (i == 2) ? 4 : -1);
      end
      @(negedge clk);
      check_bit("idle after handshake", busy_o, 1'b0);
      check_bit("valid dropped after handshake", frame_valid_o, 1'b0);

      // Overrun: byte arriving while the frame is held
      frame_ready_i = 1'b0;
      send_frame(vecs[0].payload, vecs[0].crc_tx, 1'b0, -1);
      put(8'hAA);
      check_bit("overrun pulse", overrun_o, 1'b1);
      check_vec("frame kept on overrun", frame_o, vecs[0].payload);
      check_bit("valid kept on overrun", frame_valid_o, 1'b1);
      @(negedge clk);
      check_bit("overrun single cycle", overrun_o, 1'b0);
      check_vec("frame still held", frame_o, vecs[0].payload);

      // Handshake and first byte of the next frame in the same cycle
      frame_ready_i = 1'b1;
      send_frame(vecs[4].payload, vecs[4].crc_tx, 1'b0, -1);
      @(negedge clk);

      // Idle gap inside a frame
`ifdef CRC_FRAME_RX_TIMEOUT_EN
      put(8'h01);
      put(8'h02);
      repeat (15) @(negedge clk);
      check_bit("no timeout before limit", timeout_o, 1'b0);
      check_bit("busy before limit", busy_o, 1'b1);
      @(negedge clk);
      check_bit("timeout pulse", timeout_o, 1'b1);
      check_bit("idle after timeout", busy_o, 1'b0);
      @(negedge clk);
      check_bit("timeout single cycle", timeout_o, 1'b0);
      send_frame(vecs[0].payload, vecs[0].crc_tx, 1'b0, -1);
      @(negedge clk);
`else
      put(8'h01);
      put(8'h02);
      repeat (40) @(negedge clk);
      check_bit("timeout tied low", timeout_o, 1'b0);
      check_bit("collect waits indefinitely", busy_o, 1'b1);
`endif

      // Asynchronous reset in the middle of a frame
      put(8'h31);
      put(8'h32);
      put(8'h33);
      check_bit("busy mid frame", busy_o, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      check_bit("async reset busy_o", busy_o, 1'b0);
      check_bit("async reset frame_valid_o", frame_valid_o, 1'b0);
      check_vec("async reset frame_o", frame_o, '0);
      check_bit("async reset crc_err_o", crc_err_o, 1'b0);
      check_bit("async reset overrun_o", overrun_o, 1'b0);
      check_bit("async reset timeout_o", timeout_o, 1'b0);
      @(negedge clk);
      rst_ni = 1'b1;
      send_frame(vecs[0].payload, vecs[0].crc_tx, 1'b0, -1);
      @(negedge clk);

      check_vec("pending frames", FW'(sb_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
